// File: rtl/async_reg_load_ctrl_pkg.sv
// Shared types and widths for the asynchronous register-load controller.
package async_reg_load_ctrl_pkg;
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;
  localparam int ADDR_W = 2;
  localparam int CNT_W  = 16;
endpackage

// File: rtl/async_reg_load_ctrl_sync_bit.sv
// Single-bit multi-flop synchronizer; every stage is tagged for placement as a sync chain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/async_reg_load_ctrl.sv
// Loads a small config register bank from an async source over a 4-phase req/ack handshake.
module async_reg_load_ctrl
  import async_reg_load_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_async,
  input  logic [ADDR_W-1:0]   addr_async,
  input  logic [DATA_W-1:0]   data_async,
  output logic                ack,
  output logic [DATA_W-1:0]   reg0_q,
  output logic [DATA_W-1:0]   reg1_q,
  output logic [DATA_W-1:0]   reg2_q,
  output logic [NUM_REGS-1:0] load_pulse,
  output logic                addr_err,
  output logic [CNT_W-1:0]    xfer_cnt
);
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic                w_req_s;
  logic                w_accept;
  logic                w_done;
  logic                w_addr_ok;
  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_load;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   w_out [3];

  sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (req_async),
    .o_q   (w_req_s)
  );

  // addr/data are not synchronized: the sender holds them until ack, so they
  // are settled by the time the synchronized req is seen.
  assign w_addr_ok = {1'b0, addr_async} < NREGS;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (w_req_s) begin
        w_state_nxt = ACK;
        w_accept    = 1'b1;
      end
      ACK: if (!w_req_s) begin
        w_state_nxt = IDLE;
        w_done      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_load <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_load <= '0;
      if (w_accept) begin
        if (w_addr_ok) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_async == ADDR_W'(i)) begin
              r_regs[i] <= data_async;
              r_load[i] <= 1'b1;
            end
          end
        end else begin
          r_err <= 1'b1;
        end
      end
      if (w_done) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Fixed three output ports; slots beyond NUM_REGS read as zero.
  for (genvar g = 0; g < 3; g++) begin : g_out
    if (g < NUM_REGS) begin : g_live
      assign w_out[g] = r_regs[g];
    end else begin : g_tie
      assign w_out[g] = '0;
    end
  end

  assign reg0_q     = w_out[0];
  assign reg1_q     = w_out[1];
  assign reg2_q     = w_out[2];
  assign ack        = (r_state == ACK);
  assign load_pulse = r_load;
  assign addr_err   = r_err;
  assign xfer_cnt   = r_cnt;
endmodule

// File: tb/tb_async_reg_load_ctrl.sv
// Scoreboarded bench for async_reg_load_ctrl: handshake timing, bank contents, errors, reset, wrap.
module tb_async_reg_load_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_async = 1'b0;
  logic [1:0]  addr_async = '0;
  logic [31:0] data_async = '0;
  logic        ack;
  logic [31:0] reg0_q, reg1_q, reg2_q;
  logic [2:0]  load_pulse;
  logic        addr_err;
  logic [15:0] xfer_cnt;

  async_reg_load_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_async  (req_async),
    .addr_async (addr_async),
    .data_async (data_async),
    .ack        (ack),
    .reg0_q     (reg0_q),
    .reg1_q     (reg1_q),
    .reg2_q     (reg2_q),
    .load_pulse (load_pulse),
    .addr_err   (addr_err),
    .xfer_cnt   (xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model [3];
  logic [15:0] exp_cnt;
  logic        exp_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input logic [1:0] a);
    case (a)
      2'd0:    return reg0_q;
      2'd1:    return reg1_q;
      default: return reg2_q;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bank(input string tag);
    chk({tag, "_r0"}, reg0_q, model[0]);
    chk({tag, "_r1"}, reg1_q, model[1]);
    chk({tag, "_r2"}, reg2_q, model[2]);
  endtask

  task automatic clr_model();
    for (int i = 0; i < 3; i++) model[i] = '0;
    exp_cnt = '0;
    exp_err = 1'b0;
  endtask

  // One full protocol-respecting handshake, checking ack edges around the write.
  task automatic xfer(input logic [1:0] a, input logic [31:0] d);
    logic        ok;
    logic [31:0] lp;
    ok = (a < 2'd3);
    lp = ok ? (32'd1 << a) : 32'd0;
    addr_async = a;
    data_async = d;
    req_async  = 1'b1;
    if (ok) begin
      sb_q.push_back({a, d});
      model[a] = d;
    end else begin
      exp_err = 1'b1;
    end
    step(); chk("ack_k0", 32'(ack), 32'd0);
    step(); chk("ack_k1", 32'(ack), 32'd0); chk("lp_k1", 32'(load_pulse), 32'd0);
    step(); chk("ack_rise", 32'(ack), 32'd1); chk("lp_rise", 32'(load_pulse), lp);
    chk("err", 32'(addr_err), 32'(exp_err));
    chk_bank("wr");
    req_async = 1'b0;
    step(); chk("ack_hold", 32'(ack), 32'd1); chk("lp_once", 32'(load_pulse), 32'd0);
    step();
    step(); exp_cnt++;
    chk("ack_fall", 32'(ack), 32'd0);
    chk("cnt", 32'(xfer_cnt), 32'(exp_cnt));
  endtask

  // Scoreboard: every load_pulse must match the oldest outstanding expected write.
  always begin : mon
    wr_t w;
    @(posedge clk);
    #1;
    if (load_pulse != '0) begin
      if (sb_q.size() == 0) begin
        chk("sb_extra", 32'(load_pulse), 32'd0);
      end else begin
        w = sb_q.pop_front();
        chk("sb_pulse", 32'(load_pulse), 32'd1 << w.addr);
        chk("sb_data", reg_of(w.addr), w.data);
      end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_model();
    repeat (3) step();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_lp", 32'(load_pulse), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
    chk("rst_cnt", 32'(xfer_cnt), 32'd0);
    chk_bank("rst");
    rst_n = 1'b1;
    repeat (4) step();
    chk("idle_ack", 32'(ack), 32'd0);

    xfer(2'd1, 32'hDEAD_BEEF);
    xfer(2'd3, 32'h1234_5678);
    xfer(2'd0, 32'h1111_1111);
    chk("err_sticky", 32'(addr_err), 32'd1);
    xfer(2'd2, 32'hCAFE_F00D);

    // Bus changes while in ACK must not cause writes.
    addr_async = 2'd0; data_async = 32'hA5A5_A5A5; req_async = 1'b1;
    sb_q.push_back({2'd0, 32'hA5A5_A5A5});
    model[0] = 32'hA5A5_A5A5;
    repeat (3) step();
    chk("ack_a5", 32'(ack), 32'd1);
    addr_async = 2'd1; data_async = 32'hFFFF_0000;
    repeat (3) begin
      step();
      chk("ackbus_lp", 32'(load_pulse), 32'd0);
      chk("ackbus_ack", 32'(ack), 32'd1);
    end
    chk_bank("ackbus");

    // Reset in ACK with req held high: immediate clear, then re-accept.
    rst_n = 1'b0;
    #1;
    clr_model();
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_err", 32'(addr_err), 32'd0);
    chk("arst_cnt", 32'(xfer_cnt), 32'd0);
    chk("arst_lp", 32'(load_pulse), 32'd0);
    chk_bank("arst");
    step(); step();
    chk("inrst_ack", 32'(ack), 32'd0);
    addr_async = 2'd0; data_async = 32'hA5A5_A5A5;
    sb_q.push_back({2'd0, 32'hA5A5_A5A5});
    model[0] = 32'hA5A5_A5A5;
    rst_n = 1'b1;
    step(); chk("rec_k0", 32'(ack), 32'd0);
    step(); chk("rec_k1", 32'(ack), 32'd0);
    step(); chk("rec_ack", 32'(ack), 32'd1);
    chk_bank("rec");
    req_async = 1'b0;
    repeat (3) step();
    exp_cnt++;
    chk("rec_fall", 32'(ack), 32'd0);
    chk("rec_cnt", 32'(xfer_cnt), 32'(exp_cnt));

    // Counter wrap: 65535 fast handshakes with fixed addr/data, then one full one.
    rst_n = 1'b0;
    step();
    clr_model();
    rst_n = 1'b1;
    step(); step();
    addr_async = 2'd2; data_async = 32'h5EED_0001;
    for (int i = 0; i < 65535; i++) begin
      req_async = 1'b1;
      sb_q.push_back({2'd2, 32'h5EED_0001});
      step();
      req_async = 1'b0;
      step();
    end
    model[2] = 32'h5EED_0001;
    exp_cnt  = 16'hFFFF;
    repeat (4) step();
    chk("pre_wrap_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    chk("pre_wrap_ack", 32'(ack), 32'd0);
    xfer(2'd2, 32'h7777_2222);
    chk("wrap_cnt", 32'(xfer_cnt), 32'd0);
    chk("wrap_r2", reg2_q, 32'h7777_2222);

    repeat (4) step();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
